// File: rtl/beep_player.sv
// Multi-tune square-wave buzzer engine: note ROM, elaboration-time pitch table,
// tick-based note durations, one-shot or looped playback.
module beep_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int TUNE_LEN    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  tune_sel,
  input  logic                        loop_en,
  input  logic                        stop,
  input  logic                        mute,
  output logic                        beep,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(TUNE_LEN)-1:0] note_idx
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | latch ROM entry at idx, clear tone/tick counters, decode END
  // PLAY  | sound note or rest for (len+1) ticks
  // FIN   | one-cycle done pulse after a non-looped tune
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int  IDX_W  = $clog2(TUNE_LEN);
  localparam int  TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam real SEMI   = 1.0594630943592953;
  localparam logic [4:0] P_END = 5'd31;

  // Equal-temperament half period in clk cycles, code 10 = A4 = 440 Hz.
  function automatic int half_of(input int k);
    real f;
    f = 440.0;
    if (k >= 10) begin
      for (int i = 10; i < k; i++) f = f * SEMI;
    end else begin
      for (int i = k; i < 10; i++) f = f / SEMI;
    end
    return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
  endfunction

  localparam int HALF_MAX = half_of(1);
  localparam int CNT_W    = $clog2(HALF_MAX + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(TUNE_LEN - 1);
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_CYCLES - 1);

  function automatic logic [7:0] rom_entry(input logic [1:0] tune,
                                           input logic [IDX_W-1:0] idx);
    logic [7:0] e;
    int         i;
    i = int'(idx);
    e = {P_END, 3'd0};
    case (tune)
      2'd0: begin
        case (i)
          0: e = {5'd1,  3'd0};
          1: e = {5'd5,  3'd0};
          2: e = {5'd8,  3'd0};
          3: e = {5'd13, 3'd0};
          default: e = {P_END, 3'd0};
        endcase
      end
      2'd1: begin
        case (i)
          0: e = {5'd17, 3'd0};
          1: e = {5'd20, 3'd1};
          default: e = {P_END, 3'd0};
        endcase
      end
      2'd2: begin
        case (i)
          0: e = {5'd8, 3'd1};
          1: e = {5'd0, 3'd0};
          2: e = {5'd5, 3'd1};
          3: e = {5'd1, 3'd3};
          default: e = {P_END, 3'd0};
        endcase
      end
      default: begin
        case (i)
          0: e = {5'd1, 3'd0};
          1: e = {5'd3, 3'd0};
          2: e = {5'd5, 3'd0};
          3: e = {5'd1, 3'd0};
          default: e = {P_END, 3'd0};
        endcase
      end
    endcase
    return e;
  endfunction

  logic [CNT_W-1:0] half_tab [32];
  for (genvar k = 0; k < 32; k++) begin : g_half
    if (k >= 1 && k <= 24) begin : g_tone
      assign half_tab[k] = CNT_W'(half_of(k));
    end else begin : g_rest
      assign half_tab[k] = '0;
    end
  end

  logic [1:0]        state_q, state_d;
  logic [1:0]        tune_q, tune_d;
  logic              loop_q, loop_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic [4:0]        pitch_q, pitch_d;
  logic [2:0]        len_q, len_d;
  logic [CNT_W-1:0]  half_cnt_q, half_cnt_d;
  logic              phase_q, phase_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        note_tick_q, note_tick_d;
  logic              beep_q, beep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]       rom_q;
  logic             is_end;
  logic             tone_on;
  logic             tick_last;
  logic [CNT_W-1:0] half_m1;

  assign rom_q     = rom_entry(tune_q, idx_q);
  // A tune that fills every slot without END still terminates.
  assign is_end    = wrap_q || (rom_q[7:3] == P_END);
  assign tone_on   = (pitch_q != 5'd0) && (pitch_q <= 5'd24);
  assign tick_last = (tick_cnt_q == TICK_TOP);
  assign half_m1   = half_tab[pitch_q] - 1'b1;

  always_comb begin
    state_d     = state_q;
    tune_d      = tune_q;
    loop_d      = loop_q;
    idx_d       = idx_q;
    wrap_d      = wrap_q;
    pitch_d     = pitch_q;
    len_d       = len_q;
    half_cnt_d  = half_cnt_q;
    phase_d     = phase_q;
    tick_cnt_d  = tick_cnt_q;
    note_tick_d = note_tick_q;

    case (state_q)
      S_LOAD: begin
        pitch_d     = rom_q[7:3];
        len_d       = rom_q[2:0];
        half_cnt_d  = '0;
        phase_d     = 1'b0;
        tick_cnt_d  = '0;
        note_tick_d = '0;
        if (is_end) begin
          if (loop_q) begin
            state_d = S_LOAD;
            idx_d   = '0;
            wrap_d  = 1'b0;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tone_on) begin
          if (half_cnt_q == half_m1) begin
            half_cnt_d = '0;
            phase_d    = ~phase_q;
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
        if (tick_last) begin
          tick_cnt_d = '0;
          if (note_tick_q == len_q) begin
            state_d = S_LOAD;
            if (idx_q == IDX_LAST) wrap_d = 1'b1;
            else                   idx_d  = idx_q + 1'b1;
          end else begin
            note_tick_d = note_tick_q + 3'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    if (start) begin
      state_d = S_LOAD;
      tune_d  = tune_sel;
      loop_d  = loop_en;
      idx_d   = '0;
      wrap_d  = 1'b0;
    end
    if (stop) begin
      state_d = S_IDLE;
    end
  end

  // Output stage lags the phase by one cycle and drops as soon as PLAY is left.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    beep_d = (state_q == S_PLAY) && (state_d == S_PLAY) && tone_on &&
             phase_q && !mute;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tune_q      <= 2'd0;
      loop_q      <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      pitch_q     <= 5'd0;
      len_q       <= 3'd0;
      half_cnt_q  <= '0;
      phase_q     <= 1'b0;
      tick_cnt_q  <= '0;
      note_tick_q <= 3'd0;
      beep_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tune_q      <= tune_d;
      loop_q      <= loop_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      pitch_q     <= pitch_d;
      len_q       <= len_d;
      half_cnt_q  <= half_cnt_d;
      phase_q     <= phase_d;
      tick_cnt_q  <= tick_cnt_d;
      note_tick_q <= note_tick_d;
      beep_q      <= beep_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign beep     = beep_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_beep_player.sv
// Directed bench for beep_player: one DUT at the test-plan timing, a second
// with longer ticks so full half-periods fit inside a note.
module tb_beep_player;

  localparam int CLK_HZ = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, loop_en = 1'b0, stop = 1'b0, mute = 1'b0;
  logic [1:0] tune_sel = 2'd0;
  logic       beep, busy, done;
  logic [3:0] note_idx;

  logic       p_start = 1'b0, p_stop = 1'b0;
  logic [1:0] p_sel = 2'd0;
  logic       p_beep, p_busy, p_done;
  logic [3:0] p_note_idx;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  int w_done_t, w_done_n, w_busy_n, w_beep_n, w_rise_t, w_end_t, w_nidx;
  int w_idx_t [8];
  int w_idx_v [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beep_player #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(1_000), .TUNE_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tune_sel(tune_sel),
    .loop_en(loop_en), .stop(stop), .mute(mute), .beep(beep), .busy(busy),
    .done(done), .note_idx(note_idx)
  );

  beep_player #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(4_000), .TUNE_LEN(16)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(p_start), .tune_sel(p_sel),
    .loop_en(1'b0), .stop(p_stop), .mute(1'b0), .beep(p_beep), .busy(p_busy),
    .done(p_done), .note_idx(p_note_idx)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] tsel, input logic lp);
    tune_sel = tsel;
    loop_en  = lp;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // t = 0 is the sample right after the start edge.
  task automatic watch(input int max_cyc, input bit stop_on_idle);
    int prev_idx;
    w_done_t = -1; w_done_n = 0; w_busy_n = 0; w_beep_n = 0;
    w_rise_t = -1; w_end_t = -1; w_nidx = 0;
    for (int i = 0; i < 8; i++) begin w_idx_t[i] = -1; w_idx_v[i] = -1; end
    prev_idx = int'(note_idx);
    for (int t = 0; t < max_cyc; t++) begin
      if (done) begin
        w_done_n++;
        if (w_done_t < 0) w_done_t = t;
      end
      if (busy && !done) w_busy_n++;
      if (beep) begin
        w_beep_n++;
        if (w_rise_t < 0) w_rise_t = t;
      end
      if (int'(note_idx) != prev_idx && w_nidx < 8) begin
        w_idx_t[w_nidx] = t;
        w_idx_v[w_nidx] = int'(note_idx);
        w_nidx++;
      end
      prev_idx = int'(note_idx);
      if (stop_on_idle && !busy) begin
        w_end_t = t;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic p_wait(input bit on_idx, input int val, input int maxc, output int t);
    t = -1;
    for (int i = 0; i < maxc; i++) begin
      if ((on_idx ? int'(p_note_idx) : int'(p_beep)) == val) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pitch_tune(input logic [1:0] tsel, input int n,
                            input int h0, input int h1, input int h2, input int h3);
    int h [4];
    int tl, tr, tf;
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    p_sel   = tsel;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    tl = cyc;
    for (int k = 0; k < n; k++) begin
      if (k > 0) p_wait(1'b1, k, 20000, tl);
      p_wait(1'b0, 1, 10000, tr);
      p_wait(1'b0, 0, 10000, tf);
      check_val($sformatf("pitch_t%0d_n%0d_rise", tsel, k), tr - tl, h[k] + 2);
      check_val($sformatf("pitch_t%0d_n%0d_half", tsel, k), tf - tr, h[k]);
    end
    p_stop = 1'b1;
    @(negedge clk);
    p_stop = 1'b0;
    check_val($sformatf("pitch_t%0d_stop_busy", tsel), int'(p_busy), 0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_val("rst_beep", int'(beep), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_idx", int'(note_idx), 0);
    rst_n = 1'b1;
    idle(2);

    // Tune 0, one-shot; tune_sel/loop_en changes after start must be ignored.
    pulse_start(2'd0, 1'b0);
    tune_sel = 2'd2;
    loop_en  = 1'b1;
    watch(6000, 1'b1);
    loop_en  = 1'b0;
    check_val("t0_busy_cycles", w_busy_n, 4005);
    check_val("t0_done_time", w_done_t, 4005);
    check_val("t0_done_count", w_done_n, 1);
    check_val("t0_busy_fall", w_end_t, 4006);
    check_val("t0_done_after", int'(done), 0);
    check_val("t0_beep_high", w_beep_n, 43);
    check_val("t0_c5_rise", w_rise_t, 3961);
    check_val("t0_idx1_t", w_idx_t[0], 1001);
    check_val("t0_idx2_t", w_idx_t[1], 2002);
    check_val("t0_idx3_t", w_idx_t[2], 3003);
    check_val("t0_idx3_v", w_idx_v[2], 3);
    idle(3);

    // Tune 2: G4 x2 ticks, rest, E4 x2, C4 x4.
    pulse_start(2'd2, 1'b0);
    watch(10000, 1'b1);
    check_val("t2_done_time", w_done_t, 9005);
    check_val("t2_beep_high", w_beep_n, 3116);
    check_val("t2_g4_rise", w_rise_t, 1278);
    check_val("t2_idx1_t", w_idx_t[0], 2001);
    check_val("t2_idx2_t", w_idx_t[1], 3002);
    check_val("t2_idx3_t", w_idx_t[2], 5003);
    check_val("t2_idx1_v", w_idx_v[0], 1);
    check_val("t2_idx2_v", w_idx_v[1], 2);
    check_val("t2_idx3_v", w_idx_v[2], 3);
    idle(3);

    // Tune 3 looped for three passes, then stop.
    pulse_start(2'd3, 1'b1);
    loop_en = 1'b0;
    watch(12100, 1'b0);
    check_val("t3_done_count", w_done_n, 0);
    check_val("t3_busy_cycles", w_busy_n, 12100);
    check_val("t3_beep_high", w_beep_n, 0);
    check_val("t3_end_slot_t", w_idx_t[3], 4004);
    check_val("t3_wrap_t", w_idx_t[4], 4005);
    check_val("t3_wrap_v", w_idx_v[4], 0);
    check_val("t3_second_pass_v", w_idx_v[5], 1);
    pulse_stop();
    check_val("t3_stop_busy", int'(busy), 0);
    check_val("t3_stop_beep", int'(beep), 0);
    idle(3);

    // Preempt tune 0 during its second note with tune 1.
    pulse_start(2'd0, 1'b0);
    idle(1500);
    check_val("pre_idx_before", int'(note_idx), 1);
    pulse_start(2'd1, 1'b0);
    watch(5000, 1'b1);
    check_val("pre_e5_rise", w_rise_t, 760);
    check_val("pre_beep_high", w_beep_n, 964);
    check_val("pre_done_time", w_done_t, 3003);
    check_val("pre_done_count", w_done_n, 1);
    check_val("pre_busy_cycles", w_busy_n, 3003);
    idle(3);

    // Reset for one cycle in the middle of an audible note.
    pulse_start(2'd2, 1'b0);
    idle(4700);
    check_val("mrst_beep_before", int'(beep), 1);
    check_val("mrst_idx_before", int'(note_idx), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("mrst_beep", int'(beep), 0);
    check_val("mrst_busy", int'(busy), 0);
    check_val("mrst_done", int'(done), 0);
    check_val("mrst_idx", int'(note_idx), 0);
    watch(50, 1'b0);
    check_val("mrst_stays_idle", w_busy_n, 0);

    // Stop while the buzzer is high.
    pulse_start(2'd2, 1'b0);
    idle(1500);
    check_val("stop_beep_before", int'(beep), 1);
    pulse_stop();
    check_val("stop_busy", int'(busy), 0);
    check_val("stop_beep", int'(beep), 0);
    watch(200, 1'b0);
    check_val("stop_no_done", w_done_n, 0);
    check_val("stop_idle", w_busy_n, 0);

    // Stop and start in the same cycle while busy.
    pulse_start(2'd0, 1'b0);
    idle(100);
    tune_sel = 2'd1;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_val("ss_busy", int'(busy), 0);
    watch(100, 1'b0);
    check_val("ss_idle", w_busy_n, 0);
    check_val("ss_no_done", w_done_n, 0);

    // Mute: silent output, unchanged timing.
    mute = 1'b1;
    pulse_start(2'd0, 1'b0);
    watch(6000, 1'b1);
    mute = 1'b0;
    check_val("mute_beep_high", w_beep_n, 0);
    check_val("mute_done_time", w_done_t, 4005);
    check_val("mute_busy_fall", w_end_t, 4006);
    idle(3);

    // Half-period measurement on the long-tick instance.
    pitch_tune(2'd0, 4, 1911, 1517, 1276, 956);
    idle(3);
    pitch_tune(2'd1, 2, 758, 638, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/beep_player.md
# beep_player

Parametrised multi-tune square-wave sound engine for the game's buzzer output. It holds four built-in melodies in a note ROM and plays the one selected on a `start` pulse, once or looped. Pitch comes from a clock-derived half-period table; note length comes from a programmable tick. It replaces the single hard-wired game-over tune generator: the top level maps game events (power-on, score, game over, background) onto `tune_sel`/`start`.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; sets the pitch half-periods.
- `TICK_CYCLES`, 12_500_000: clock cycles per duration tick (125 ms at 100 MHz).
- `TUNE_LEN`, 16: ROM slots per tune; index width is clog2(TUNE_LEN).
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising `clk`.
- `start` input 1: one-cycle request to play `tune_sel`.
- `tune_sel` input 2: tune number, 0..3.
- `loop_en` input 1: latched with `start`; 1 = repeat the tune until `stop`.
- `stop` input 1: abort playback.
- `mute` input 1: forces `beep` low; sequencing continues.
- `beep` output 1: 50 % square wave to the buzzer.
- `busy` output 1: high while a tune is playing.
- `done` output 1: one-cycle pulse when a non-looped tune finishes.
- `note_idx` output clog2(TUNE_LEN): ROM index of the current note.

## Operation
- ROM entry = {pitch[4:0], len[2:0]}. The note lasts (len+1) ticks.
- Pitch code 0 = rest (`beep` low). Codes 1..24 = C4..B5 chromatic (1=C4, 5=E4, 8=G4, 10=A4, 13=C5, 17=E5, 20=G5). Code 31 = END. Codes 25..30 are treated as rest.
- Half-period table: HALF[k] = round(CLK_HZ / (2·f_k)), with equal temperament and A4 = 440 Hz. All values are computed at elaboration time. The counter width must hold HALF[1].
- ROM contents:
  - Tune 0: C4, E4, G4, C5 (len 0 each), END.
  - Tune 1: E5 (len 0), G5 (len 1), END.
  - Tune 2: G4 (len 1), rest (len 0), E4 (len 1), C4 (len 3), END.
  - Tune 3: C4, D4, E4, C4 (len 0 each), END.
- FSM states:
  - IDLE → LOAD on `start`.
  - LOAD (one cycle) latches the ROM entry. It goes to PLAY for a note or rest, to LOAD with idx=0 for END when looping, and to FIN for END when not looping.
  - PLAY → LOAD with idx+1 when the last tick of the note expires.
  - FIN (one cycle) asserts `done` and returns to IDLE.
- On `start`, `tune_sel` and `loop_en` are latched. Later changes to these inputs are ignored until the next `start`.
- Tone generator:
  - The half-period counter and `beep` phase clear to 0 in every LOAD, so each note starts low.
  - `beep` toggles when the counter reaches HALF−1, and the counter then wraps to 0.
- Tick counter: clears in LOAD and counts 0..TICK_CYCLES−1 in PLAY. A separate counter tracks ticks per note.
- Index wrap: if idx reaches TUNE_LEN−1 without END, the next step is treated as END.
- Priorities:
  - `rst_n` low wins over everything.
  - `stop` beats `start` in the same cycle: the engine goes to IDLE, `beep`=0, `busy`=0, and `done` is not pulsed.
  - `start` while busy preempts playback and restarts at LOAD with the new tune; `done` is not pulsed for the aborted tune.
- `mute` gates only the `beep` output register. Note timing and `done` are unaffected.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets state=IDLE, `beep`=0, `busy`=0, `done`=0, `note_idx`=0, and clears all counters. This applies mid-note too.
- `start` sampled at edge N: LOAD in cycle N+1, PLAY from N+2.
  - `busy`=1 from N+1.
  - First `beep` rise at edge N+2+HALF.
- A note or rest occupies exactly (len+1)·TICK_CYCLES PLAY cycles plus 1 LOAD cycle.
- END in LOAD, non-looped: FIN is the next cycle, with `done`=1 and `busy` still 1. Both outputs are 0 the cycle after.
- Looped tune: END costs one extra LOAD cycle and never enters FIN.
- `note_idx` updates on entry to LOAD.
- All outputs are registered.

## Test plan
- Use CLK_HZ=1_000_000 and TICK_CYCLES=1_000 for all scenarios.
- Tune 0, one-shot: `start` with `tune_sel`=0 → four notes with half-periods 1911, 1517, 1276, 956 cycles (±1). `busy` stays high for 4·1000+5 cycles. Then one `done` pulse and `busy` falls in the following cycle.
- Tune 2, rest and long notes: G4 runs for 2000 cycles, then `beep` stays low for 1000 cycles, then E4 for 2000 and C4 for 4000. Check `note_idx` steps 0,1,2,3.
- Tune 3 with `loop_en`=1: `note_idx` wraps 3→0 after 4 notes. `done` never pulses over 3 loops. `stop` then drops `busy` and `beep` to 0 on the next cycle.
- Preempt: `start` tune 1 during the second note of tune 0 → E5 starts with phase 0 (half-period 758). No `done` pulse for tune 0.
- Reset and controls mid-tune: `rst_n` low for one cycle mid-note clears all outputs on the following edge. `stop` and `start` in the same cycle result in IDLE. `mute` high holds `beep` at 0 while the `done` timing is unchanged.
